// File: rtl/mux_scan_pkg.sv
// Shared types and defaults for the mux channel scanner.
package mux_scan_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_OUT} state_t;

    localparam int W_DEF      = 8;
    localparam int N_CH_DEF   = 8;
    localparam int SEL_W_DEF  = 3;
    localparam int SETTLE_DEF = 2;
    localparam int CNT_W      = 4;
endpackage

// File: rtl/mux_scan_next_ch.sv
// Finds the next enabled channel strictly after i_cur, wrapping; o_none when mask is empty.
module mux_scan_next_ch #(
    parameter int N_CH  = 8,
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0] i_cur,
    input  logic [N_CH-1:0]  i_mask,
    output logic [SEL_W-1:0] o_next,
    output logic             o_none
);
    int w_idx;

    // Walk farthest-to-nearest so the nearest enabled channel is the final write.
    always_comb begin
        o_next = '0;
        o_none = 1'b1;
        w_idx  = 0;
        for (int k = N_CH; k >= 1; k--) begin
            w_idx = (int'(i_cur) + k) % N_CH;
            if (i_mask[w_idx]) begin
                o_next = SEL_W'(w_idx);
                o_none = 1'b0;
            end
        end
    end
endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans enabled channels of an 8:1 mux, waits a settle interval, and hands samples out via valid/ready.
// Optional MUX_SCAN_CHG_ONLY_EN: suppress samples whose value matches the last one seen on that channel.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int N_CH   = N_CH_DEF,
    parameter int SEL_W  = SEL_W_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [N_CH-1:0]  ch_mask,
    output logic [SEL_W-1:0] sel,
    input  logic [W-1:0]     mux_o,
    output logic [W-1:0]     smp_data,
    output logic [SEL_W-1:0] smp_ch,
    output logic             smp_valid,
    input  logic             smp_ready,
    output logic             busy
);
    state_t           r_state;
    logic [SEL_W-1:0] r_sel;
    logic [W-1:0]     r_data;
    logic [SEL_W-1:0] r_ch;
    logic             r_valid;
    logic             r_busy;
    logic             r_stop_pend;
    logic [CNT_W-1:0] r_cnt;

    logic [SEL_W-1:0] w_cur;
    logic [SEL_W-1:0] w_next;
    logic             w_none;
    logic             w_launch;
    logic             w_capture;
    logic             w_skip;

    // From IDLE, searching after the last channel yields the lowest enabled one.
    assign w_cur = (r_state == ST_IDLE) ? SEL_W'(N_CH - 1) : r_sel;

    mux_scan_next_ch #(.N_CH(N_CH), .SEL_W(SEL_W)) u_next_ch (
        .i_cur  (w_cur),
        .i_mask (ch_mask),
        .o_next (w_next),
        .o_none (w_none)
    );

    assign w_launch  = (r_state == ST_IDLE) && start && !stop && !w_none;
    assign w_capture = (r_state == ST_SETTLE) && !stop && (r_cnt == CNT_W'(1)) && !w_skip;

`ifdef MUX_SCAN_CHG_ONLY_EN
    logic [N_CH-1:0] r_seen;
    logic [W-1:0]    r_last [N_CH];

    assign w_skip = (r_state == ST_SETTLE) && r_seen[r_sel] && (mux_o == r_last[r_sel]);

    always_ff @(posedge clk) begin
        if (rst || w_launch) begin
            r_seen <= '0;
        end else if (w_capture) begin
            r_seen[r_sel] <= 1'b1;
            r_last[r_sel] <= mux_o;
        end
    end
`else
    assign w_skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sel       <= '0;
            r_data      <= '0;
            r_ch        <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_stop_pend <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_stop_pend <= 1'b0;
                    if (w_launch) begin
                        r_sel   <= w_next;
                        r_cnt   <= CNT_W'(SETTLE);
                        r_state <= ST_SETTLE;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_W'(1)) begin
                        r_cnt <= '0;
                        if (w_skip) begin
                            // Unchanged value: advance exactly as after a handshake.
                            if (w_none) begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_sel <= w_next;
                                r_cnt <= CNT_W'(SETTLE);
                            end
                        end else begin
                            r_data  <= mux_o;
                            r_ch    <= r_sel;
                            r_valid <= 1'b1;
                            r_state <= ST_OUT;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_OUT: begin
                    if (stop) r_stop_pend <= 1'b1;
                    if (smp_ready) begin
                        r_valid <= 1'b0;
                        if (r_stop_pend || stop || w_none) begin
                            r_state     <= ST_IDLE;
                            r_busy      <= 1'b0;
                            r_stop_pend <= 1'b0;
                        end else begin
                            r_sel   <= w_next;
                            r_cnt   <= CNT_W'(SETTLE);
                            r_state <= ST_SETTLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sel       = r_sel;
    assign smp_data  = r_data;
    assign smp_ch    = r_ch;
    assign smp_valid = r_valid;
    assign busy      = r_busy;
endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Channel scanner that sits directly upstream of the 8-input, 8-bit mux (mux8t1_8).
- Drives the mux `sel` input, steps through a programmable set of enabled channels, and waits a settle interval after each select change.
- Captures the mux output `o` into a registered sample and hands it downstream over a valid/ready handshake.
- Replaces the fixed sel-stepping stimulus with a reusable synthesizable sequencer.

Parameters:
- W, 8: data width of the mux output and sample.
- N_CH, 8: number of mux channels.
- SEL_W, 3: select width, equal to clog2(N_CH).
- SETTLE, 2: cycles between a `sel` update and capture of `mux_o`. Legal range 1..15.

Ports:
- clk  in  1  single clock; rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins continuous scanning when idle.
- stop  in  1  pulse; ends scanning (see Behaviour).
- ch_mask  in  N_CH  bit i=1 enables channel i.
- sel  out  SEL_W  registered select to the mux.
- mux_o  in  W  mux output (`o`).
- smp_data  out  W  captured sample.
- smp_ch  out  SEL_W  channel of smp_data.
- smp_valid  out  1  sample available.
- smp_ready  in  1  downstream accepts the sample.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (synchronous, any state): sel=0, smp_data=0, smp_ch=0, smp_valid=0, busy=0, state=IDLE, settle counter=0. Any pending sample is dropped.
- FSM states:
  - IDLE: start=1, stop=0 and ch_mask!=0 → sel=lowest enabled channel, cnt=SETTLE, go SETTLE. Otherwise stay. start with ch_mask==0 is ignored. start and stop in the same cycle: stop wins.
  - SETTLE: cnt decrements each edge. On the edge where cnt==1: smp_data<=mux_o, smp_ch<=sel, smp_valid<=1, go OUT. Net effect: sel registered at edge k, mux_o sampled at edge k+SETTLE.
  - OUT: smp_data, smp_ch and smp_valid are held stable until an edge with smp_valid&&smp_ready. At that edge smp_valid<=0, and then:
    - if stop is pending → IDLE;
    - else if current ch_mask==0 → IDLE;
    - else sel<=next enabled channel strictly after the current one, wrapping from N_CH-1 to 0; cnt=SETTLE; go SETTLE.
- Throughput: with ready held high, one sample per SETTLE+1 cycles.
- Single enabled channel: sel is unchanged but the full SETTLE wait still applies each round.
- start while busy: ignored.
- stop in SETTLE: abort to IDLE on the next edge; no sample is produced; sel is held.
- stop in OUT: set stop_pend. The transition to IDLE occurs at handshake completion. stop_pend clears on entering IDLE.
- ch_mask is sampled only at channel selection (IDLE exit, OUT advance). Changes mid-SETTLE have no effect on the current channel.
- smp_valid never deasserts without a handshake, except on reset.
- busy is registered with the state.

Optional Feature:
- Macro: MUX_SCAN_CHG_ONLY_EN.
- Defined:
  - Per-channel last[N_CH][W] registers plus a seen[N_CH] bit. seen clears on rst and on IDLE→SETTLE.
  - At capture, if seen[sel] && mux_o==last[sel]: no sample is emitted; go straight to the advance/stop logic as if a handshake had just completed.
  - Otherwise emit the sample and update last/seen.
- Undefined: every capture is emitted; no last/seen storage exists.

Decomposition:
- Package mux_scan_pkg contains:
  - state enum {IDLE, SETTLE, OUT};
  - default W/N_CH/SEL_W/SETTLE localparams;
  - settle-counter width constant (4 bits).
- Sub-module mux_scan_next_ch:
  - Combinational finder of the next enabled channel after cur, with wrap, plus a "none" flag.
  - Also used for the lowest-enabled-channel case (cur = N_CH-1).

Test Plan (mux model mux_o = 8'h11*sel, SETTLE=2):
- Full scan: rst; ch_mask=8'hFF; pulse start; smp_ready=1 → samples (ch,data) = (0,00),(1,11)…(7,77),(0,00), one every 3 cycles.
- Sparse mask: ch_mask=8'b1010_0100 → (2,22),(5,55),(7,77),(2,22); sel never shows 0,1,3,4,6.
- Backpressure: hold smp_ready=0 for 10 cycles with sample (3,33) valid → smp_data/sel remain 33/3; on release, the next sample is (4,44) 3 cycles after the handshake.
- Stop handling:
  - stop in SETTLE → IDLE next edge, busy=0, no valid;
  - stop in OUT with ready=0 → valid held; after the handshake, IDLE.
- Reset and mask edges:
  - rst with smp_valid=1 → next edge all outputs 0;
  - start with ch_mask=0 → stays IDLE;
  - ch_mask=8'h08 → repeated (3,33).
- MUX_SCAN_CHG_ONLY_EN with static inputs → exactly 8 samples, then none. Force ch5 value to 8'hA5 → single sample (5,A5).
